// File: rtl/my_112l_pkg.sv
// rtl/my_112l_pkg.sv - shared types and constants for the instruction fetch stage
package my_112l_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [8:0]  pc;
    logic [8:0]  pcplus4;
    logic [31:0] instruction;
    logic        valid;
  } IF_ID;

  // Bubble with a harmless NOP so decode never needs to special-case valid=0
  function automatic IF_ID ifid_bubble();
    IF_ID b;
    b.pc          = '0;
    b.pcplus4     = '0;
    b.instruction = NOP_INSTR;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry capture/hold buffer for memory read data
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // Capture once on load; clear has priority so a flush/run never keeps stale data
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_valid ? r_data : i_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, sync imem interface and IF/ID register
module instruction_fetch
  import my_112l_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              IMEM_AW  = 7,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INS_W-1:0]   imem_rdata,
  output IF_ID               ifid
);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_resp_pc;
  logic             r_resp_valid;
  IF_ID             r_ifid;

  logic [INS_W-1:0] w_instr;
  logic             w_skid_valid;
  logic             w_skid_clear;
  logic             w_skid_load;
  logic [PC_W-1:0]  w_pc_plus4;
  logic [PC_W-1:0]  w_resp_plus4;
  logic [PC_W-1:0]  w_target;

  assign w_pc_plus4   = r_pc + PC_W'(4);
  assign w_resp_plus4 = r_resp_pc + PC_W'(4);
  assign w_target     = branch_target & ~PC_W'(3);

  // Memory output moves on after one cycle of stall, so grab it the first stalled cycle only
  assign w_skid_clear = reset | flush | ifid_write;
  assign w_skid_load  = ~w_skid_valid & r_resp_valid;

  fetch_skid_buf #(
    .W (INS_W)
  ) u_skid (
    .clk     (clk),
    .i_clear (w_skid_clear),
    .i_load  (w_skid_load),
    .i_data  (imem_rdata),
    .o_data  (w_instr),
    .o_valid (w_skid_valid)
  );

  // PC, response tracker and IF/ID register: reset > flush > stall > run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_resp_pc    <= '0;
      r_resp_valid <= 1'b0;
      r_ifid       <= ifid_bubble();
    end else if (flush) begin
      r_pc         <= w_target;
      r_resp_valid <= 1'b0;
      r_ifid       <= ifid_bubble();
    end else if (ifid_write) begin
      r_ifid.pc          <= r_resp_pc;
      r_ifid.pcplus4     <= w_resp_plus4;
      r_ifid.instruction <= r_resp_valid ? w_instr : NOP_INSTR;
      r_ifid.valid       <= r_resp_valid;
      if (pc_write) begin
        r_resp_pc    <= r_pc;
        r_resp_valid <= 1'b1;
        r_pc         <= w_pc_plus4;
      end else begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = r_pc[PC_W-1:2];
  assign ifid      = r_ifid;

endmodule
